// File: rtl/barrel_shift_left_pipe.sv
// rtl/barrel_shift_left_pipe.sv - pipelined left barrel shifter/rotator with valid/ready on both sides
module barrel_shift_left_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_count,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_lost
);

    logic [CNT_W-1:0]            stage_valid;
    logic [CNT_W-1:0]            stage_rot;
    logic [CNT_W-1:0]            stage_lost;
    logic [CNT_W-1:0][WIDTH-1:0] stage_data;
    logic [CNT_W-1:0][CNT_W-1:0] stage_cnt;

    logic [CNT_W-1:0]            src_rot;
    logic [CNT_W-1:0]            src_lost;
    logic [CNT_W-1:0][WIDTH-1:0] src_data;
    logic [CNT_W-1:0][CNT_W-1:0] src_cnt;

    logic [CNT_W-1:0][WIDTH-1:0] nxt_data;
    logic [CNT_W-1:0]            nxt_lost;

    logic [CNT_W-1:0]            move;
    logic [CNT_W-1:0]            load;
    logic                        cnt_unused;

    // A stage moves if the output drains or any stage below it is empty,
    // which lets bubbles collapse without a per-stage ready chain.
    always_comb begin
        logic room;
        move = '0;
        load = '0;
        room = out_ready;
        for (int i = CNT_W - 1; i >= 0; i--) begin
            move[i] = stage_valid[i] && room;
            room    = room || !stage_valid[i];
        end
        in_ready = !stage_valid[0] || move[0];
        load[0]  = in_valid && in_ready;
        for (int i = 1; i < CNT_W; i++) begin
            load[i] = move[i-1];
        end
    end

    always_comb begin
        src_data    = '0;
        src_cnt     = '0;
        src_rot     = '0;
        src_lost    = '0;
        src_data[0] = in_data;
        src_cnt[0]  = in_count;
        src_rot[0]  = in_rot;
        src_lost[0] = 1'b0;
        for (int i = 1; i < CNT_W; i++) begin
            src_data[i] = stage_data[i-1];
            src_cnt[i]  = stage_cnt[i-1];
            src_rot[i]  = stage_rot[i-1];
            src_lost[i] = stage_lost[i-1];
        end
    end

    // Stage i shifts by WIDTH>>(i+1) under count bit CNT_W-1-i (MSB first).
    always_comb begin
        int               sh;
        logic [WIDTH-1:0] spill;
        nxt_data = '0;
        nxt_lost = '0;
        for (int i = 0; i < CNT_W; i++) begin
            sh    = WIDTH >> (i + 1);
            spill = src_data[i] >> (WIDTH - sh);
            if (src_cnt[i][CNT_W-1-i]) begin
                if (src_rot[i]) begin
                    nxt_data[i] = (src_data[i] << sh) | spill;
                    nxt_lost[i] = 1'b0;
                end else begin
                    nxt_data[i] = src_data[i] << sh;
                    nxt_lost[i] = src_lost[i] || (|spill);
                end
            end else begin
                nxt_data[i] = src_data[i];
                nxt_lost[i] = src_lost[i] && !src_rot[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid <= '0;
            stage_data  <= '0;
            stage_cnt   <= '0;
            stage_rot   <= '0;
            stage_lost  <= '0;
        end else begin
            for (int i = 0; i < CNT_W; i++) begin
                if (load[i]) begin
                    stage_valid[i] <= 1'b1;
                    stage_data[i]  <= nxt_data[i];
                    stage_cnt[i]   <= src_cnt[i];
                    stage_rot[i]   <= src_rot[i];
                    stage_lost[i]  <= nxt_lost[i];
                end else if (move[i]) begin
                    stage_valid[i] <= 1'b0;
                end
            end
        end
    end

    assign out_valid  = stage_valid[CNT_W-1];
    assign out_data   = stage_data[CNT_W-1];
    assign out_lost   = stage_lost[CNT_W-1] && !stage_rot[CNT_W-1];
    assign cnt_unused = ^stage_cnt[CNT_W-1];

endmodule

// File: tb/tb_barrel_shift_left_pipe.sv
// tb/tb_barrel_shift_left_pipe.sv - randomized and directed bench against a behavioural shift model
module tb_barrel_shift_left_pipe;

    localparam int W  = 8;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data = '0;
    logic [CW-1:0] in_count = '0;
    logic          in_rot = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_lost;

    barrel_shift_left_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_count(in_count), .in_rot(in_rot),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_lost(out_lost)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] exp_q[$];
    int         exp_c[$];
    logic [8:0] log_v[$];
    int         log_lat[$];
    int         log_cyc[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // {lost, data}: widen, shift by plain arithmetic, then fold or test the overflow byte.
    function automatic logic [8:0] ref_shift(input logic [7:0] d, input int c, input logic r);
        logic [15:0] w;
        w = {8'h00, d} << c;
        if (r) return {1'b0, w[7:0] | w[15:8]};
        return {|w[15:8], w[7:0]};
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            exp_c.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 32'(out_valid), 32'(0));
                end else begin
                    chk("out_data", 32'(out_data), 32'(exp_q[0][7:0]));
                    chk("out_lost", 32'(out_lost), 32'(exp_q[0][8]));
                    if (out_ready) begin
                        chk("latency_min", 32'(cyc - exp_c[0] >= CW), 32'(1));
                        log_v.push_back({out_lost, out_data});
                        log_lat.push_back(cyc - exp_c[0]);
                        log_cyc.push_back(cyc);
                        void'(exp_q.pop_front());
                        void'(exp_c.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(in_data, int'(in_count), in_rot));
                exp_c.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic clear_log();
        log_v.delete();
        log_lat.delete();
        log_cyc.delete();
    endtask

    task automatic send(input logic [7:0] d, input logic [2:0] c, input logic r);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_count = c;
        in_rot   = r;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", 32'(acc), 32'(1));
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int accepted;

        #1;
        chk("reset_out_valid", 32'(out_valid), 32'(0));
        chk("reset_out_data", 32'(out_data), 32'(0));
        chk("reset_out_lost", 32'(out_lost), 32'(0));
        step();
        step();
        rst = 1'b0;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'(1));

        chk("pin_b5_3_log", 32'(ref_shift(8'hB5, 3, 1'b0)), 32'h1A8);
        chk("pin_b5_3_rot", 32'(ref_shift(8'hB5, 3, 1'b1)), 32'h0AD);
        chk("pin_03_7_log", 32'(ref_shift(8'h03, 7, 1'b0)), 32'h180);

        out_ready = 1'b1;
        clear_log();
        send(8'hB5, 3'd3, 1'b0);
        idle(5);
        chk("lat_count", 32'(log_v.size()), 32'(1));
        if (log_v.size() >= 1) begin
            chk("lat_result", 32'(log_v[0]), 32'h1A8);
            chk("lat_cycles", 32'(log_lat[0]), 32'(3));
        end

        clear_log();
        send(8'hB5, 3'd3, 1'b1);
        send(8'h3C, 3'd0, 1'b0);
        send(8'h01, 3'd7, 1'b0);
        send(8'h03, 3'd7, 1'b0);
        idle(6);
        chk("edge_count", 32'(log_v.size()), 32'(4));
        if (log_v.size() == 4) begin
            chk("edge_rot3", 32'(log_v[0]), 32'h0AD);
            chk("edge_cnt0", 32'(log_v[1]), 32'h03C);
            chk("edge_01_7", 32'(log_v[2]), 32'h080);
            chk("edge_03_7", 32'(log_v[3]), 32'h180);
        end

        clear_log();
        for (int k = 0; k < 4; k++) send(8'h01, 3'(k), 1'b0);
        idle(6);
        chk("thru_count", 32'(log_v.size()), 32'(4));
        if (log_v.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("thru_data", 32'(log_v[k]), 32'(9'h001 << k));
                chk("thru_lat", 32'(log_lat[k]), 32'(3));
            end
        end

        out_ready = 1'b0;
        clear_log();
        accepted = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_count = 3'($urandom);
            in_rot   = 1'($urandom);
            @(negedge clk);
            if (!in_ready) break;
            @(posedge clk);
            #1;
            accepted++;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 32'(accepted), 32'(3));
        idle(3);
        chk("bp_hold_valid", 32'(out_valid), 32'(1));
        chk("bp_full_ready", 32'(in_ready), 32'(0));
        out_ready = 1'b1;
        #1;
        chk("bp_ready_on_drain", 32'(in_ready), 32'(1));
        idle(6);
        chk("bp_drained", 32'(log_v.size()), 32'(3));
        chk("bp_queue_empty", 32'(exp_q.size()), 32'(0));

        out_ready = 1'b0;
        clear_log();
        send(8'h11, 3'd1, 1'b0);
        idle(1);
        send(8'h22, 3'd2, 1'b1);
        idle(4);
        out_ready = 1'b1;
        idle(4);
        chk("bubble_count", 32'(log_v.size()), 32'(2));
        if (log_v.size() == 2) begin
            chk("bubble_first", 32'(log_v[0]), 32'h022);
            chk("bubble_second", 32'(log_v[1]), 32'h088);
            chk("bubble_adjacent", 32'(log_cyc[1] - log_cyc[0]), 32'(1));
        end

        for (int k = 0; k < 400; k++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = 8'($urandom);
            in_count  = 3'($urandom);
            in_rot    = 1'($urandom);
            out_ready = ($urandom % 4) != 0;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(10);
        chk("rand_drained", 32'(exp_q.size()), 32'(0));

        out_ready = 1'b0;
        send(8'hB5, 3'd3, 1'b0);
        send(8'h3C, 3'd1, 1'b0);
        idle(1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_lost", 32'(out_lost), 32'(0));
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rst_no_stale", 32'(out_valid), 32'(0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/barrel_shift_left_pipe.md
Name: barrel_shift_left_pipe

Overview:
- Pipelined left barrel shifter/rotator with valid/ready handshakes on both sides. It is the left-direction counterpart of the team's combinational logical-right barrel shifter.
- Shifting is split into log2(WIDTH) registered stages: shift by WIDTH/2 first, then halve down to 1, one stage per count bit, MSB first.
- It feeds datapath consumers that need full throughput (one item per clock) and can apply backpressure.
- Also reports whether any nonzero bits were discarded by a logical shift.

Parameters:
- WIDTH, 8, data width in bits. Must be a power of two, >= 2.
- CNT_W, $clog2(WIDTH) (default 3), shift-count width. Also the number of pipeline stages. Derived; do not override.

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_count/in_rot are valid
- in_ready  output  1  block accepts an input this cycle
- in_data  input  WIDTH  operand
- in_count  input  CNT_W  left shift amount, 0..WIDTH-1
- in_rot  input  1  1 = rotate left, 0 = logical shift left (zero fill)
- out_valid  output  1  out_data/out_lost are valid
- out_ready  input  1  downstream accepts output this cycle
- out_data  output  WIDTH  shifted/rotated result
- out_lost  output  1  logical mode only: 1 if any 1-bit was shifted out past the MSB; always 0 in rotate mode

Behaviour:
- Pipeline structure: CNT_W stages S1..S_CNT_W.
  - Stage k applies a shift/rotate of WIDTH>>k when the corresponding count bit (bit CNT_W-k) is 1; otherwise it passes data through.
  - Each stage registers: valid, data, remaining count bits, rot flag, lost accumulator.
  - Output ports are driven directly from the last stage's registers.
- Per-stage move rule: stage k loads from its upstream when that upstream holds a valid item and (stage k is empty or stage k's item moves on this cycle).
  - Last stage moves on when out_valid && out_ready.
  - in_ready = !S1.valid || S1 moves this cycle (combinational from stage valids and out_ready).
  - Accept occurs on a rising edge with in_valid && in_ready.
- Bubbles collapse: an empty stage loads regardless of downstream state.
- Latency: an item accepted on edge t is presented on out_* after edge t+CNT_W-1 when unstalled. Default: out_valid high in the 3rd cycle counting the accept cycle as cycle 1.
- Throughput: 1 item per clock when out_ready stays high.
- Capacity: CNT_W items in flight. When full and out_ready=0, in_ready=0.
- Stall: while out_valid && !out_ready, out_data/out_lost/out_valid hold stable. No item is dropped, duplicated, or reordered.
- Logical mode: zero-fill from the LSB. Each stage ORs the bits it discards into lost; out_lost is the OR across all stages.
- Rotate mode: bits leaving the MSB re-enter at the LSB. lost is forced to 0.
- in_count = 0: out_data = in_data, out_lost = 0, latency unchanged.
- Inputs sampled only on accept. in_data/in_count/in_rot are don't-care when in_valid=0.
- Reset (asynchronous, any time, including mid-operation):
  - All stage valids clear immediately, so out_valid=0 immediately.
  - All data, count, rot and lost registers clear to 0, so out_data=0 and out_lost=0.
  - In-flight items are discarded.
  - in_ready=1 once rst deasserts; first accept is possible on the first edge after deassertion.
- No handshake outputs depend combinationally on in_valid.

Test Plan:
- Logical shift: in_data=8'hB5, count=3, rot=0, out_ready=1 -> out_data=8'hA8, out_lost=1, out_valid in 3rd cycle after accept.
- Rotate and edge counts:
  - 8'hB5, count=3, rot=1 -> out_data=8'hAD, out_lost=0.
  - 8'h3C, count=0 -> 8'h3C, lost=0.
  - 8'h01, count=7, logical -> 8'h80, lost=0.
  - 8'h03, count=7, logical -> 8'h80, lost=1.
- Throughput: four back-to-back accepts (8'h01 counts 0,1,2,3, logical), out_ready=1 -> outputs 8'h01, 8'h02, 8'h04, 8'h08 on consecutive cycles, in order.
- Backpressure: out_ready=0, push items until in_ready=0 -> exactly 3 accepted, out_data held stable. Raise out_ready -> 3 items drain in order, no duplicates; in_ready returns to 1 the same cycle the first item leaves.
- Bubble collapse: accept one item, idle 1 cycle, accept second, with out_ready=0 then 1 -> no empty output cycle between the two results once both are resident.
- Reset mid-flight: assert rst asynchronously (between edges) with 2 items in flight -> out_valid=0 and out_data=0 before the next edge. After deassert, no stale item ever appears at the output.
